// File: rtl/addition_normalizer_packer_if.sv
// addition_normalizer_packer_if: operand/result handshake bundle of the FP adder back end
interface addition_normalizer_packer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int MENT_WIDTH = 23,
  parameter int EXPO_WIDTH = 8
) ();
  logic                  in_valid;
  logic                  in_ready;
  logic                  sign_in;
  logic [EXPO_WIDTH-1:0] exponent_in;
  logic [MENT_WIDTH+1:0] mantissa_in;
  logic [2:0]            grs_in;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] result_out;
  logic                  busy_out;
  modport master (
    output in_valid, sign_in, exponent_in, mantissa_in, grs_in, out_ready,
    input  in_ready, out_valid, result_out, busy_out
  );
  modport slave (
    input  in_valid, sign_in, exponent_in, mantissa_in, grs_in, out_ready,
    output in_ready, out_valid, result_out, busy_out
  );
endinterface

// File: rtl/addition_normalizer_packer.sv
// addition_normalizer_packer: normalize one bit per cycle, round-to-nearest-even and pack an FP add result
module addition_normalizer_packer #(
  parameter int DATA_WIDTH = 32,
  parameter int MENT_WIDTH = 23,
  parameter int EXPO_WIDTH = 8
) (
  input logic clk,
  input logic rst_n,
  addition_normalizer_packer_if.slave bus
);
  localparam int XW = EXPO_WIDTH + 1;
  localparam int MW = MENT_WIDTH + 2;
  typedef enum logic [1:0] {IDLE, NORM, ROUND, HOLD} state_t;
  state_t                state;
  logic                  sgn;
  logic [XW-1:0]         exp;
  logic [MW-1:0]         man;
  logic [2:0]            grs;
  logic [DATA_WIDTH-1:0] res;
  logic                  inc;
  logic [MW-1:0]         m;
  logic [XW-1:0]         exp_r;
  logic [DATA_WIDTH-1:0] packed_r;
  // a rounding carry out of the hidden bit leaves m's fraction bits all zero
  always_comb begin
    inc = grs[2] & (grs[1] | grs[0] | man[0]);
    m = MW'(man[MENT_WIDTH:0]) + MW'(inc);
    exp_r = m[MW-1] ? exp + XW'(1) : (exp == '0 && m[MENT_WIDTH]) ? XW'(1) : exp;
    packed_r = exp_r >= XW'({EXPO_WIDTH{1'b1}}) ? {sgn, {EXPO_WIDTH{1'b1}}, {MENT_WIDTH{1'b0}}}
                                                : {sgn, exp_r[EXPO_WIDTH-1:0], m[MENT_WIDTH-1:0]};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sgn <= 1'b0;
      exp <= '0;
      man <= '0;
      grs <= '0;
      res <= '0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          sgn <= bus.sign_in;
          exp <= {1'b0, bus.exponent_in};
          man <= bus.mantissa_in;
          grs <= bus.grs_in;
          state <= NORM;
        end
        NORM: if (man == '0 && grs == '0) begin
          res <= {sgn, {(DATA_WIDTH-1){1'b0}}};
          state <= HOLD;
        end else if (man[MW-1]) begin
          man <= man >> 1;
          grs <= {man[0], grs[2], grs[1] | grs[0]};
          exp <= exp + XW'(1);
          state <= ROUND;
        end else if (man[MENT_WIDTH]) begin
          state <= ROUND;
        end else if (exp <= XW'(1)) begin
          exp <= '0;
          state <= ROUND;
        end else begin
          man <= {man[MW-2:0], grs[2]};
          grs <= {grs[1:0], 1'b0};
          exp <= exp - XW'(1);
        end
        ROUND: begin
          res <= packed_r;
          state <= HOLD;
        end
        HOLD: if (bus.out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
  assign bus.in_ready   = state == IDLE;
  assign bus.out_valid  = state == HOLD;
  assign bus.busy_out   = state != IDLE;
  assign bus.result_out = res;
endmodule
